// File: rtl/hazard_ctrl.sv
// hazard_ctrl: producer-side hazard controller for a 5-stage MIPS pipeline.
//
// Shadows the destination register, write-enable and remaining result
// latency (Tnew) of the instructions in E, M and W. Compares the D-stage
// operand needs (Tuse) against them and raises stall/e_clr. A small counter
// tracks how long the multiply/divide unit keeps HI/LO busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   d_rs, d_rt            D-stage source register addresses
//   d_tuse_rs, d_tuse_rt  cycles until the operand is needed (3 = unused)
//   d_dst, d_we, d_tnew   D-stage destination, write-enable, result latency
//   d_md_start, d_md_div  D is mult/div (d_md_div selects divide)
//   d_md_use              D is mfhi/mflo/mthi/mtlo
//   stall, e_clr          hold F/D and PC; bubble the D/E register
//   e_/m_/w_ad, _we       per-stage destination and effective write-enable
//   e_delay, m_delay      remaining Tnew in E and M
//   md_busy               multiply/divide unit busy
//
// Optional (macro HAZARD_STATS_EN):
//   stall_cnt             saturating count of stalled cycles
//   md_stall_cnt          saturating count of md-caused stalled cycles
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_dst,
  input  logic        d_we,
  input  logic [1:0]  d_tnew,
  input  logic        d_md_start,
  input  logic        d_md_div,
  input  logic        d_md_use,
  output logic        stall,
  output logic        e_clr,
  output logic [4:0]  e_ad,
  output logic [4:0]  m_ad,
  output logic [4:0]  w_ad,
  output logic        e_we,
  output logic        m_we,
  output logic        w_we,
  output logic [1:0]  e_delay,
  output logic [1:0]  m_delay,
  output logic        md_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             e_we_r, m_we_r, w_we_r;
  logic             e_md_start, e_md_div;
  logic [CNT_W-1:0] md_cnt;
  logic             rs_haz, rt_haz, md_haz;

  // Register $0 is never a real destination, so it never forwards or stalls.
  assign e_we    = e_we_r && (e_ad != 5'd0);
  assign m_we    = m_we_r && (m_ad != 5'd0);
  assign w_we    = w_we_r && (w_ad != 5'd0);
  assign md_busy = (md_cnt != '0);

  // A producer blocks only while its remaining latency exceeds the
  // consumer's slack. W is always forwardable and never participates.
  always_comb begin
    rs_haz = (d_tuse_rs != 2'd3) && (d_rs != 5'd0) &&
             ((e_we && (e_ad == d_rs) && (e_delay > d_tuse_rs)) ||
              (m_we && (m_ad == d_rs) && (m_delay > d_tuse_rs)));
    rt_haz = (d_tuse_rt != 2'd3) && (d_rt != 5'd0) &&
             ((e_we && (e_ad == d_rt) && (e_delay > d_tuse_rt)) ||
              (m_we && (m_ad == d_rt) && (m_delay > d_tuse_rt)));
    // e_md_start covers the cycle before the counter has been loaded.
    md_haz = (d_md_use || d_md_start) && (md_busy || e_md_start);
    stall  = rs_haz || rt_haz || md_haz;
    e_clr  = stall;
  end

  // Pipeline shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ad       <= 5'd0;
      e_we_r     <= 1'b0;
      e_delay    <= 2'd0;
      e_md_start <= 1'b0;
      e_md_div   <= 1'b0;
      m_ad       <= 5'd0;
      m_we_r     <= 1'b0;
      m_delay    <= 2'd0;
      w_ad       <= 5'd0;
      w_we_r     <= 1'b0;
    end else begin
      w_ad    <= m_ad;
      w_we_r  <= m_we_r;
      m_ad    <= e_ad;
      m_we_r  <= e_we_r;
      m_delay <= (e_delay == 2'd0) ? 2'd0 : e_delay - 2'd1;
      if (stall) begin
        e_ad       <= 5'd0;
        e_we_r     <= 1'b0;
        e_delay    <= 2'd0;
        e_md_start <= 1'b0;
        e_md_div   <= 1'b0;
      end else begin
        e_ad       <= d_dst;
        e_we_r     <= d_we;
        e_delay    <= d_tnew;
        e_md_start <= d_md_start;
        e_md_div   <= d_md_div;
      end
    end
  end

  // HI/LO busy counter: loads when the md instruction leaves E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (e_md_start) begin
      md_cnt <= e_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= 32'd0;
      md_stall_cnt <= 32'd0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (md_haz && (md_stall_cnt != 32'hFFFF_FFFF))
        md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_we, d_md_start, d_md_div, d_md_use;
  logic        stall, e_clr;
  logic [4:0]  e_ad, m_ad, w_ad;
  logic        e_we, m_we, w_we;
  logic [1:0]  e_delay, m_delay;
  logic        md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAZARD_STATS_EN
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt),
`endif
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_dst      (d_dst),
    .d_we       (d_we),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .e_clr      (e_clr),
    .e_ad       (e_ad),
    .m_ad       (m_ad),
    .w_ad       (w_ad),
    .e_we       (e_we),
    .m_we       (m_we),
    .w_we       (w_we),
    .e_delay    (e_delay),
    .m_delay    (m_delay),
    .md_busy    (md_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_dst = 5'd0; d_we = 1'b0; d_tnew = 2'd0;
    d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (14) tick();
  endtask

  task automatic produce(input logic [4:0] dst, input logic [1:0] tnew);
    idle_inputs();
    d_dst = dst; d_we = 1'b1; d_tnew = tnew;
  endtask

  // Tests
  task automatic test_reset();
    logic [24:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_rs = 5'($urandom_range(0, 31)); d_rt = 5'($urandom_range(0, 31));
      d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
      d_dst = 5'($urandom_range(0, 31)); d_we = 1'($urandom_range(0, 1));
      d_tnew = 2'($urandom_range(0, 2)); d_md_start = 1'($urandom_range(0, 1));
      d_md_div = 1'($urandom_range(0, 1)); d_md_use = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs = {stall, e_clr, e_ad, m_ad, w_ad, e_we, m_we, w_we, e_delay, m_delay, md_busy};
      tests_run++;
      if (obs !== 25'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
      end
`ifdef HAZARD_STATS_EN
      tests_run++;
      if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_cnt, md_stall_cnt);
      end
`endif
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_stall: got %b expected 0", stall);
    end
    tick();
  endtask

  task automatic test_load_use();
    produce(5'd8, 2'd2);
    tick();
    idle_inputs();
    d_rs = 5'd8; d_tuse_rs = 2'd0;
    @(negedge clk);
    tests_run++;
    if (e_ad !== 5'd8 || e_delay !== 2'd2 || e_we !== 1'b1 || stall !== 1'b1 || e_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_c1: e_ad=%0d e_delay=%0d e_we=%b stall=%b e_clr=%b expected 8 2 1 1 1",
               e_ad, e_delay, e_we, stall, e_clr);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || m_ad !== 5'd8 || m_delay !== 2'd1 || e_ad !== 5'd0) begin
      tests_failed++;
      $display("FAIL load_use_c2: stall=%b m_ad=%0d m_delay=%0d e_ad=%0d expected 1 8 1 0",
               stall, m_ad, m_delay, e_ad);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || w_ad !== 5'd8 || w_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_c3: stall=%b w_ad=%0d w_we=%b expected 0 8 1", stall, w_ad, w_we);
    end
    tick();
    drain();
  endtask

  task automatic test_alu_chain();
    produce(5'd9, 2'd1);
    tick();
    idle_inputs();
    d_rt = 5'd9; d_tuse_rt = 2'd1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || e_delay !== 2'd1) begin
      tests_failed++;
      $display("FAIL alu_chain_stall: stall=%b e_delay=%0d expected 0 1", stall, e_delay);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (m_ad !== 5'd9 || m_delay !== 2'd0 || m_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_chain_m: m_ad=%0d m_delay=%0d m_we=%b expected 9 0 1", m_ad, m_delay, m_we);
    end
    drain();
  endtask

  task automatic test_zero_unused();
    produce(5'd0, 2'd2);
    tick();
    idle_inputs();
    d_rs = 5'd0; d_tuse_rs = 2'd0;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || e_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_reg: stall=%b e_we=%b expected 0 0", stall, e_we);
    end
    tick();
    produce(5'd7, 2'd2);
    tick();
    idle_inputs();
    d_rt = 5'd7; d_tuse_rt = 2'd3; d_rs = 5'd7; d_tuse_rs = 2'd3;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || e_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL unused_operand: stall=%b e_we=%b expected 0 1", stall, e_we);
    end
    drain();
  endtask

  // Strict greater-than boundary and both operands hazarding together.
  task automatic test_back_to_back();
    produce(5'd12, 2'd2);
    tick();
    idle_inputs();
    d_rs = 5'd12; d_tuse_rs = 2'd1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL tuse1_e_stage: stall=%b expected 1", stall);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL tuse1_m_stage: stall=%b expected 0", stall);
    end
    tick();
    drain();
    produce(5'd5, 2'd2);
    tick();
    idle_inputs();
    d_rs = 5'd5; d_tuse_rs = 2'd0; d_rt = 5'd5; d_tuse_rt = 2'd0;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || e_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL rs_rt_both: stall=%b e_clr=%b expected 1 1", stall, e_clr);
    end
    tick();
    drain();
  endtask

  task automatic test_md(input logic div, input int cycles);
    idle_inputs();
    d_md_start = 1'b1; d_md_div = div;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL md_start_div%0b: stall=%b expected 0", div, stall);
    end
    tick();
    idle_inputs();
    d_md_use = 1'b1;
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1 || md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL md_e_stage_div%0b: stall=%b md_busy=%b expected 1 0", div, stall, md_busy);
    end
    tick();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      tests_run++;
      if (stall !== 1'b1 || md_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL md_busy_div%0b cycle %0d: stall=%b md_busy=%b expected 1 1",
                 div, i, stall, md_busy);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL md_done_div%0b: stall=%b md_busy=%b expected 0 0", div, stall, md_busy);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    d_md_start = 1'b1; d_md_div = 1'b1;
    tick();
    idle_inputs();
    d_md_use = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_stall_pre: stall=%b expected 1", stall);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0 || md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_stall_reset: stall=%b md_busy=%b expected 0 0", stall, md_busy);
    end
`ifdef HAZARD_STATS_EN
    tests_run++;
    if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_stall_stats: got %0d/%0d expected 0/0", stall_cnt, md_stall_cnt);
    end
`endif
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    test_load_use();
    test_md(1'b1, 10);
    @(negedge clk);
    tests_run++;
    if (stall_cnt !== 32'd13 || md_stall_cnt !== 32'd11) begin
      tests_failed++;
      $display("FAIL stats_counts: got %0d/%0d expected 13/11", stall_cnt, md_stall_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_alu_chain();
    test_zero_unused();
    test_back_to_back();
    test_md(1'b1, 10);
    test_md(1'b0, 5);
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
